// File: rtl/serial_pair_msb_first_feeder_pkg.sv
// ============================================================================
// Module  : serial_feeder_pkg
// Purpose : Shared types for the MSB-first serial pair feeder.
//           - control FSM state encoding
//           - bit-counter width helper
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_feeder_pkg;

  // Control states. CLEAR is only entered when SERIAL_FEEDER_CLEAR_GAP_EN is defined.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } feeder_state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Bits needed to count WIDTH-1 down to 0.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_pair_msb_first_feeder_if.sv
// ============================================================================
// Module  : serial_pair_msb_first_feeder_if
// Purpose : Parallel-in handshake plus serial-out bus of the pair feeder.
// Signals : in_valid/in_ready/in_a/in_b  - parallel word pair handshake
//           ser_valid/ser_a/ser_b         - serial data bits, MSB first
//           ser_first/ser_last/cmp_clear  - framing for the downstream comparator
// Modports: master - producer of pairs / consumer of serial stream
//           slave  - the feeder itself
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_pair_msb_first_feeder_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             ser_valid;
  logic             ser_a;
  logic             ser_b;
  logic             ser_first;
  logic             ser_last;
  logic             cmp_clear;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, ser_valid, ser_a, ser_b, ser_first, ser_last, cmp_clear
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, ser_valid, ser_a, ser_b, ser_first, ser_last, cmp_clear
  );

endinterface

`default_nettype wire

// File: rtl/serial_pair_msb_first_feeder_piso.sv
// ============================================================================
// Module  : piso_shift_msb_first
// Purpose : WIDTH-bit parallel-load register that shifts left (zero fill)
//           and presents its MSB. Load has priority over shift.
// Ports   : clk, rst (async active-high)
//           load_i  - capture data_i
//           shift_i - shift left by one
//           data_i  - parallel word
//           msb_o   - current MSB
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_shift_msb_first #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load_i,
  input  wire logic             shift_i,
  input  wire logic [WIDTH-1:0] data_i,
  output logic                  msb_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (shift_i) begin
      data_d = {data_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb_o = data_q[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/serial_pair_msb_first_feeder.sv
// ============================================================================
// Module  : serial_pair_msb_first_feeder
// Purpose : Accepts (a, b) word pairs over valid/ready and streams both words
//           bit-serially MSB first, with first/last/clear framing so the
//           downstream comparator restarts on every pair.
// Ports   : clk  - clock
//           rst  - asynchronous active-high reset
//           bus  - serial_pair_msb_first_feeder_if.slave
// Option  : SERIAL_FEEDER_CLEAR_GAP_EN - insert a one-cycle CLEAR state
//           (cmp_clear pulse, no data) before every word pair.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_pair_msb_first_feeder
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic                            clk,
  input  wire logic                            rst,
  serial_pair_msb_first_feeder_if.slave        bus
);

  localparam int            CW      = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

`ifdef SERIAL_FEEDER_CLEAR_GAP_EN
  localparam feeder_state_e LOAD_NEXT = CLEAR;
`else
  localparam feeder_state_e LOAD_NEXT = SHIFT;
`endif

  feeder_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic load;
  logic shift;
  logic ready;
  logic valid;
  logic first;
  logic last;
  logic msb_a;
  logic msb_b;
`ifdef SERIAL_FEEDER_CLEAR_GAP_EN
  logic clr_gap;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    ready   = 1'b0;
    valid   = 1'b0;
    first   = 1'b0;
    last    = 1'b0;
`ifdef SERIAL_FEEDER_CLEAR_GAP_EN
    clr_gap = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          cnt_d   = CNT_TOP;
          state_d = LOAD_NEXT;
        end
      end
`ifdef SERIAL_FEEDER_CLEAR_GAP_EN
      CLEAR: begin
        clr_gap = 1'b1;
        state_d = SHIFT;
      end
`endif
      SHIFT: begin
        valid = 1'b1;
        first = (cnt_q == CNT_TOP);
        last  = (cnt_q == '0);
        shift = 1'b1;
        if (last) begin
          // LSB cycle doubles as the accept slot for the next pair.
          ready = 1'b1;
          if (bus.in_valid) begin
            load    = 1'b1;
            cnt_d   = CNT_TOP;
            state_d = LOAD_NEXT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  piso_shift_msb_first #(.WIDTH(WIDTH)) u_sh_a (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (bus.in_a),
    .msb_o   (msb_a)
  );

  piso_shift_msb_first #(.WIDTH(WIDTH)) u_sh_b (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (bus.in_b),
    .msb_o   (msb_b)
  );

  // IDLE would otherwise advertise ready while reset is held.
  assign bus.in_ready  = ready & ~rst;
  assign bus.ser_valid = valid;
  assign bus.ser_a     = valid & msb_a;
  assign bus.ser_b     = valid & msb_b;
  assign bus.ser_first = first;
  assign bus.ser_last  = last;
`ifdef SERIAL_FEEDER_CLEAR_GAP_EN
  assign bus.cmp_clear = clr_gap;
`else
  // Comparator restart is folded into the MSB cycle.
  assign bus.cmp_clear = first;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_pair_msb_first_feeder.sv
// ============================================================================
// Module  : tb_serial_pair_msb_first_feeder
// Purpose : Self-checking bench for serial_pair_msb_first_feeder. Expected
//           serial stream is kept as a queue of per-cycle beats generated
//           from each accepted word pair.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_pair_msb_first_feeder;

  localparam int WIDTH = 8;
`ifdef SERIAL_FEEDER_CLEAR_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif
  localparam int PERIOD = WIDTH + (GAP ? 1 : 0);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_pair_msb_first_feeder_if #(.WIDTH(WIDTH)) bus_if ();

  serial_pair_msb_first_feeder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic             valid;
    logic             a;
    logic             b;
    logic             first;
    logic             last;
    logic             clr;
    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] wb;
  } beat_t;

  beat_t            exp_q[$];
  int               n_total = 0;
  int               n_bad   = 0;
  int               cyc     = 0;
  int               first_cyc[$];
  logic [WIDTH-1:0] obs_a = '0;
  logic [WIDTH-1:0] obs_b = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t idle_beat();
    beat_t t;
    t.valid = 1'b0; t.a = 1'b0; t.b = 1'b0;
    t.first = 1'b0; t.last = 1'b0; t.clr = 1'b0;
    t.wa = '0; t.wb = '0;
    return t;
  endfunction

  // One accepted pair becomes: optional clear beat, then WIDTH data beats MSB first.
  function automatic void push_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    beat_t t;
    if (GAP) begin
      t = idle_beat();
      t.clr = 1'b1;
      exp_q.push_back(t);
    end
    for (int i = 0; i < WIDTH; i++) begin
      t = idle_beat();
      t.valid = 1'b1;
      t.a     = a[WIDTH-1-i];
      t.b     = b[WIDTH-1-i];
      t.first = (i == 0);
      t.last  = (i == WIDTH - 1);
      t.clr   = GAP ? 1'b0 : (i == 0);
      t.wa    = a;
      t.wb    = b;
      exp_q.push_back(t);
    end
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus_if.in_valid = v;
    bus_if.in_a     = a;
    bus_if.in_b     = b;
  endtask

  // One clock: check outputs at negedge, advance the model at posedge.
  task automatic step(output bit xfer);
    beat_t e;
    bit    rdy;
    @(negedge clk);
    e   = (exp_q.size() != 0) ? exp_q[0] : idle_beat();
    rdy = (exp_q.size() <= 1);
    check_val("in_ready",  32'(bus_if.in_ready),  32'(rdy));
    check_val("ser_valid", 32'(bus_if.ser_valid), 32'(e.valid));
    check_val("ser_a",     32'(bus_if.ser_a),     32'(e.a));
    check_val("ser_b",     32'(bus_if.ser_b),     32'(e.b));
    check_val("ser_first", 32'(bus_if.ser_first), 32'(e.first));
    check_val("ser_last",  32'(bus_if.ser_last),  32'(e.last));
    check_val("cmp_clear", 32'(bus_if.cmp_clear), 32'(e.clr));
    if (bus_if.ser_valid) begin
      if (bus_if.ser_first) begin
        first_cyc.push_back(cyc);
        obs_a = WIDTH'(bus_if.ser_a);
        obs_b = WIDTH'(bus_if.ser_b);
      end else begin
        obs_a = {obs_a[WIDTH-2:0], bus_if.ser_a};
        obs_b = {obs_b[WIDTH-2:0], bus_if.ser_b};
      end
      if (bus_if.ser_last && e.last) begin
        check_val("word_a",     32'(obs_a), 32'(e.wa));
        check_val("cmp_a_gt_b", 32'(obs_a > obs_b), 32'(e.wa > e.wb));
      end
    end
    xfer = bus_if.in_valid && rdy;
    @(posedge clk);
    cyc++;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (xfer) push_pair(bus_if.in_a, bus_if.in_b);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    bit x;
    for (int i = 0; i < n; i++) step(x);
  endtask

  // Hold valid with the given pair until accepted (bounded).
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
    bit x;
    int n;
    drive(1'b1, a, b);
    n = 0;
    do begin
      step(x);
      n++;
    end while (!x && n < 100);
    if (!x) check_val({tag, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    bit x;
    drive(1'b0, '0, '0);

    // Outputs while reset is held.
    #1;
    check_val("rst_in_ready",  32'(bus_if.in_ready),  32'd0);
    check_val("rst_ser_valid", 32'(bus_if.ser_valid), 32'd0);
    repeat (2) @(negedge clk);
    check_val("rst_in_ready2", 32'(bus_if.in_ready),  32'd0);
    rst = 1'b0;

    // Idle after reset.
    idle_cycles(10);

    // Single pair A5/A4.
    send(8'hA5, 8'hA4, "single");
    drive(1'b0, '0, '0);
    idle_cycles(PERIOD + 2);

    // Back-to-back pairs with valid held.
    first_cyc.delete();
    send(8'h10, 8'h20, "b2b0");
    send(8'hFF, 8'hFF, "b2b1");
    drive(1'b0, '0, '0);
    idle_cycles(PERIOD + 3);
    check_val("b2b_firsts", 32'(first_cyc.size()), 32'd2);
    if (first_cyc.size() == 2)
      check_val("b2b_period", 32'(first_cyc[1] - first_cyc[0]), 32'(PERIOD));

    // Valid offered mid-word is only taken on the LSB cycle.
    send(8'hA5, 8'hA4, "mid0");
    send(8'h00, 8'h00, "mid1");
    drive(1'b0, '0, '0);
    idle_cycles(PERIOD + 2);

    // Asynchronous reset after three bits of C3.
    send(8'hC3, 8'h3C, "abort");
    drive(1'b0, '0, '0);
    idle_cycles(3);
    check_val("pre_rst_valid", 32'(bus_if.ser_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_val("arst_ser_valid", 32'(bus_if.ser_valid), 32'd0);
    check_val("arst_ser_a",     32'(bus_if.ser_a),     32'd0);
    check_val("arst_ser_b",     32'(bus_if.ser_b),     32'd0);
    check_val("arst_ser_first", 32'(bus_if.ser_first), 32'd0);
    check_val("arst_ser_last",  32'(bus_if.ser_last),  32'd0);
    check_val("arst_cmp_clear", 32'(bus_if.cmp_clear), 32'd0);
    check_val("arst_in_ready",  32'(bus_if.in_ready),  32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(WIDTH + 2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom));
      step(x);
    end
    drive(1'b0, '0, '0);
    idle_cycles(PERIOD + 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_pair_msb_first_feeder.md
Name: serial_pair_msb_first_feeder

Overview:
- Upstream stage of the MSB-first serial comparator.
- Accepts a pair of parallel WIDTH-bit words (a, b) over a valid/ready handshake.
- Shifts both words out bit-serially, MSB first, on ser_a/ser_b.
- Generates framing (first/last/clear) so the downstream comparator restarts on every word pair without a global reset.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous active-high reset
in_valid  input  1  parallel pair offered
in_ready  output  1  feeder accepts pair this cycle (in_valid & in_ready = transfer)
in_a  input  WIDTH  word a
in_b  input  WIDTH  word b
ser_valid  output  1  ser_a/ser_b carry a data bit this cycle
ser_a  output  1  current bit of a (MSB first)
ser_b  output  1  current bit of b (MSB first)
ser_first  output  1  high with MSB bit of each word pair
ser_last  output  1  high with LSB bit; downstream result is final after this cycle
cmp_clear  output  1  one-cycle pulse, downstream comparator must reset its state

Behaviour:
- Reset (async assert, sync release): state=IDLE, shift regs=0, bit counter=0. All outputs 0 while rst high, including in_ready.
- States: IDLE, CLEAR (only with feature), SHIFT.
- IDLE:
  - in_ready=1, ser_valid=0, ser_a=ser_b=0.
  - On transfer: load sh_a<=in_a, sh_b<=in_b, cnt<=WIDTH-1; go to SHIFT (or CLEAR with feature).
- SHIFT:
  - ser_valid=1, ser_a=sh_a[WIDTH-1], ser_b=sh_b[WIDTH-1].
  - ser_first=(cnt==WIDTH-1); ser_last=(cnt==0).
  - Each cycle shift sh_a/sh_b left by one (zero fill) and decrement cnt.
- Latency: MSB appears on the first cycle after the accepting edge. One pair occupies exactly WIDTH SHIFT cycles.
- Back-to-back: in_ready=1 also in SHIFT when cnt==0.
  - Transfer there reloads immediately; the next cycle is the new MSB with ser_first=1.
  - No transfer at cnt==0: go to IDLE.
- in_ready=0 in SHIFT with cnt!=0. in_a/in_b are ignored unless a transfer occurs.
- cmp_clear without feature: equals ser_first (comparator clears on first bit; restart is combined with the MSB cycle downstream).
- ser_first and ser_last never both high (WIDTH>=2).
- Reset mid-word: stream aborts immediately, outputs go 0, the partial word is discarded, no ser_last is emitted.
- cnt width: $clog2(WIDTH). No wrap beyond 0, because reload or IDLE always follows.

Optional Feature:
Macro SERIAL_FEEDER_CLEAR_GAP_EN.
- Defined:
  - Every transfer goes to CLEAR for exactly one cycle: cmp_clear=1, ser_valid=0, in_ready=0; then SHIFT.
  - Back-to-back transfer at cnt==0 also passes through CLEAR.
  - Throughput is WIDTH+1 cycles per pair; ser_first unchanged (MSB cycle).
- Undefined: CLEAR state does not exist; cmp_clear = ser_first; throughput is WIDTH cycles per pair.

Decomposition:
- Package serial_feeder_pkg: state enum (IDLE, CLEAR, SHIFT as logic[1:0]) and localparam for the counter width function.
- One natural sub-module: piso_shift_msb_first (WIDTH-bit load/shift register with MSB output), instantiated twice for a and b.
- Control FSM and counter stay in the top module.

Test Plan:
- Reset then idle, no in_valid for 10 cycles -> in_ready=1, ser_valid=0, all ser_* 0.
- WIDTH=8, transfer a=8'hA5, b=8'hA4 -> next 8 cycles ser_a=1,0,1,0,0,1,0,1 and ser_b=1,0,1,0,0,1,0,0; ser_first on cycle 1, ser_last on cycle 8; comparator result a>b.
- Two pairs back-to-back ((8'h10,8'h20) then (8'hFF,8'hFF)) with in_valid held -> 16 contiguous ser_valid cycles, second ser_first immediately after first ser_last; in_ready high only in IDLE and on the cnt==0 cycles.
- in_valid asserted during mid-word cycles 2..7 with a=8'h00 -> not accepted (in_ready=0); accepted only on the ser_last cycle.
- rst asserted asynchronously after 3 bits of 8'hC3 -> outputs drop to 0 without a clock edge; after release, state is IDLE and in_ready=1; no ser_last is seen.
- With SERIAL_FEEDER_CLEAR_GAP_EN, transfer (8'h01,8'h02) -> one cycle cmp_clear=1 with ser_valid=0, then 8 data cycles; back-to-back period is 9 cycles.
